ram_seq_ctrl: RTL and testbench

RAM_SEQ_CTRL -- requirements
Module: ram_seq_ctrl

---
 rtl/ram_seq_pkg.sv | 23 ++
 rtl/ram_addr_counter.sv | 29 ++
 rtl/ram_seq_ctrl.sv | 129 ++++++++++++
 tb/tb_ram_seq_ctrl.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/ram_seq_pkg.sv
// Shared types and defaults for the RAM capture/readback sequencer.
// RAM_READBACK_EN adds the READ state to the state encoding.
package ram_seq_pkg;

  localparam int              ADDR_W   = 11;
  localparam logic [ADDR_W-1:0] ADDR_TOP = 11'h7FF;

`ifdef RAM_READBACK_EN
  typedef enum logic [1:0] {
    ST_IDLE,
    ST_FILL,
    ST_FULL,
    ST_READ
  } state_t;
`else
  typedef enum logic [1:0] {
    ST_IDLE,
    ST_FILL,
    ST_FULL
  } state_t;
`endif

endpackage

// File: rtl/ram_addr_counter.sv
// Loadable address down-counter shared by the fill and read sweeps.
// Saturates at zero so a sweep can never wrap back to the top address.
module ram_addr_counter
  import ram_seq_pkg::*;
#(
  parameter int                ADDR_W   = ram_seq_pkg::ADDR_W,
  parameter logic [ADDR_W-1:0] ADDR_TOP = ram_seq_pkg::ADDR_TOP
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic              dec,
  output logic [ADDR_W-1:0] count,
  output logic              is_zero
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= ADDR_TOP;
    end else if (load) begin
      count <= ADDR_TOP;
    end else if (dec && !is_zero) begin
      count <= count - 1'b1;
    end
  end

  assign is_zero = (count == '0);

endmodule

// File: rtl/ram_seq_ctrl.sv
// Capture sequencer: fills RAM top-down from averaged samples, then optionally
// streams it back out. Macro RAM_READBACK_EN enables the READ sweep.
module ram_seq_ctrl #(
  parameter int                ADDR_W   = ram_seq_pkg::ADDR_W,
  parameter logic [ADDR_W-1:0] ADDR_TOP = ram_seq_pkg::ADDR_TOP
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              abort,
  input  logic              average_done,
  input  logic              read_req,
  output logic [ADDR_W-1:0] address_out,
  output logic              write_ram,
  output logic              read_ram,
  output logic              rd_valid,
  output logic              busy,
  output logic              full,
  output logic              overrun
);

  import ram_seq_pkg::*;

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] addr_nxt;
  logic              wr_nxt, rd_nxt, ovr_nxt;
  logic              cnt_load, cnt_dec;
  logic [ADDR_W-1:0] count;
  logic              is_zero;

`ifndef RAM_READBACK_EN
  logic unused_read_req;
  assign unused_read_req = read_req;
`endif

  ram_addr_counter #(
    .ADDR_W   (ADDR_W),
    .ADDR_TOP (ADDR_TOP)
  ) u_counter (
    .clk     (clk),
    .reset   (reset),
    .load    (cnt_load),
    .dec     (cnt_dec),
    .count   (count),
    .is_zero (is_zero)
  );

  always_comb begin
    state_nxt = state;
    addr_nxt  = address_out;
    wr_nxt    = 1'b1;
    rd_nxt    = 1'b0;
    ovr_nxt   = overrun;
    cnt_load  = 1'b0;
    cnt_dec   = 1'b0;
    if (abort) begin
      state_nxt = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            state_nxt = ST_FILL;
            cnt_load  = 1'b1;
            ovr_nxt   = 1'b0;
          end
        end
        ST_FILL: begin
          // The write of address 0 is the last one; the counter holds at 0.
          if (average_done) begin
            wr_nxt   = 1'b0;
            addr_nxt = count;
            if (is_zero) state_nxt = ST_FULL;
            else         cnt_dec   = 1'b1;
          end
        end
        ST_FULL: begin
          if (start) begin
            state_nxt = ST_FILL;
            cnt_load  = 1'b1;
            ovr_nxt   = 1'b0;
          end else begin
            if (average_done) ovr_nxt = 1'b1;
`ifdef RAM_READBACK_EN
            if (read_req) begin
              state_nxt = ST_READ;
              cnt_load  = 1'b1;
            end
`endif
          end
        end
`ifdef RAM_READBACK_EN
        ST_READ: begin
          rd_nxt   = 1'b1;
          addr_nxt = count;
          if (is_zero) state_nxt = ST_IDLE;
          else         cnt_dec   = 1'b1;
        end
`endif
        default: state_nxt = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= ST_IDLE;
      address_out <= ADDR_TOP;
      write_ram   <= 1'b1;
      read_ram    <= 1'b0;
      rd_valid    <= 1'b0;
      overrun     <= 1'b0;
    end else begin
      state       <= state_nxt;
      address_out <= addr_nxt;
      write_ram   <= wr_nxt;
      read_ram    <= rd_nxt;
      rd_valid    <= read_ram;
      overrun     <= ovr_nxt;
    end
  end

`ifdef RAM_READBACK_EN
  assign busy = (state == ST_FILL) || (state == ST_READ);
`else
  assign busy = (state == ST_FILL);
`endif
  assign full = (state == ST_FULL);

endmodule

// File: tb/tb_ram_seq_ctrl.sv
// Directed bench for ram_seq_ctrl: scoreboarded write/read address streams
// plus point checks of flags, abort handling and asynchronous reset.
`timescale 1ns/1ps
module tb_ram_seq_ctrl;

  localparam int           AW  = 11;
  localparam logic [AW-1:0] TOP = 11'h7FF;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic          average_done = 1'b0;
  logic          read_req = 1'b0;
  logic [AW-1:0] address_out;
  logic          write_ram, read_ram, rd_valid, busy, full, overrun;

  int            errors = 0;
  int            checks = 0;
  logic [AW-1:0] wr_q[$];
  logic [AW-1:0] rd_q[$];
  logic [AW-1:0] nxt_addr;
  logic          prev_read = 1'b0;

  always #250 clk = ~clk;

  ram_seq_ctrl #(
    .ADDR_W   (AW),
    .ADDR_TOP (TOP)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .abort        (abort),
    .average_done (average_done),
    .read_req     (read_req),
    .address_out  (address_out),
    .write_ram    (write_ram),
    .read_ram     (read_ram),
    .rd_valid     (rd_valid),
    .busy         (busy),
    .full         (full),
    .overrun      (overrun)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic writes(input int n, input bit gaps);
    for (int i = 0; i < n; i++) begin
      wr_q.push_back(nxt_addr);
      nxt_addr = nxt_addr - 1'b1;
      average_done = 1'b1;
      tick();
      average_done = 1'b0;
      if (gaps) repeat ($urandom_range(0, 2)) tick();
    end
  endtask

  // Every strobe cycle must match the next expected address in order.
  always @(negedge clk) begin
    if (!reset) begin
      if (write_ram === 1'b0) begin
        if (wr_q.size() == 0) chk("wr_unexpected", write_ram, 1'b1);
        else                  chk("wr_addr", address_out, wr_q.pop_front());
      end
      if (read_ram === 1'b1) begin
        if (rd_q.size() == 0) chk("rd_unexpected", read_ram, 1'b0);
        else                  chk("rd_addr", address_out, rd_q.pop_front());
      end
      if (prev_read || rd_valid) chk("rd_valid_lag", rd_valid, prev_read);
      prev_read <= read_ram;
    end else begin
      prev_read <= 1'b0;
    end
  end

  initial begin
    #45_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    #10 reset = 1'b1;
    #10;
    chk("rst_addr", address_out, TOP);
    chk("rst_wr", write_ram, 1'b1);
    chk("rst_rd", read_ram, 1'b0);
    chk("rst_rdv", rd_valid, 1'b0);
    chk("rst_ovr", overrun, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_full", full, 1'b0);
    @(posedge clk);
    #1 reset = 1'b0;
    tick();

    // start and abort together: abort wins
    start = 1'b1; abort = 1'b1;
    tick();
    start = 1'b0; abort = 1'b0;
    chk("sa_busy", busy, 1'b0);
    chk("sa_full", full, 1'b0);
    tick();
    chk("sa_idle", busy, 1'b0);

    // sweep 1: back-to-back burst, ignored start, then gapped fill to full
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("fill_busy", busy, 1'b1);
    chk("fill_wr_idle", write_ram, 1'b1);
    nxt_addr = TOP;
    writes(5, 1'b0);
    tick();
    chk("b2b_drained", wr_q.size(), 0);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("start_in_fill", busy, 1'b1);
    writes(2043, 1'b1);
    chk("full_set", full, 1'b1);
    chk("full_busy", busy, 1'b0);
    tick();
    chk("full_drained", wr_q.size(), 0);

    // sample while full: no write, sticky overrun
    average_done = 1'b1;
    tick();
    average_done = 1'b0;
    chk("ovr_set", overrun, 1'b1);
    chk("ovr_nowrite", write_ram, 1'b1);
    repeat (3) tick();
    chk("ovr_sticky", overrun, 1'b1);
    chk("full_hold", full, 1'b1);
`ifndef RAM_READBACK_EN
    read_req = 1'b1;
    tick();
    read_req = 1'b0;
    chk("noread_full", full, 1'b1);
    chk("noread_rr", read_ram, 1'b0);
`endif

    // sweep 2 from FULL
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("ovr_clr", overrun, 1'b0);
    chk("refill_busy", busy, 1'b1);
    nxt_addr = TOP;
    writes(2048, 1'b1);
    chk("full2", full, 1'b1);

`ifdef RAM_READBACK_EN
    read_req = 1'b1;
    for (int i = 0; i < 2048; i++) rd_q.push_back(TOP - AW'(i));
    tick();
    read_req = 1'b0;
    chk("read_busy", busy, 1'b1);
    for (int i = 0; i < 2100 && busy === 1'b1; i++) tick();
    chk("read_done", busy, 1'b0);
    chk("read_full_clr", full, 1'b0);
    tick();
    chk("rd_valid_tail", rd_valid, 1'b1);
    chk("rd_off", read_ram, 1'b0);
    tick();
    chk("rd_valid_end", rd_valid, 1'b0);
    chk("rd_drained", rd_q.size(), 0);
    read_req = 1'b1;
    tick();
    read_req = 1'b0;
    chk("rreq_idle_ign", busy, 1'b0);
`endif

    // sweep 3: asynchronous reset while the 3A0 strobe is active
    start = 1'b1;
    tick();
    start = 1'b0;
    nxt_addr = TOP;
    writes(int'(TOP) - 32'h3A0 + 1, 1'b0);
    @(negedge clk);
    #50;
    chk("pre_rst_addr", address_out, 11'h3A0);
    reset = 1'b1;
    #1;
    chk("arst_addr", address_out, TOP);
    chk("arst_wr", write_ram, 1'b1);
    chk("arst_busy", busy, 1'b0);
    chk("arst_full", full, 1'b0);
    chk("arst_rd", read_ram, 1'b0);
    chk("arst_drained", wr_q.size(), 0);
    #100 reset = 1'b0;
    tick();

    // sweep 4 restarts at the top, then abort mid-fill
    start = 1'b1;
    tick();
    start = 1'b0;
    nxt_addr = TOP;
    writes(3, 1'b1);
    tick();
    chk("restart_drained", wr_q.size(), 0);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("abort_fill_busy", busy, 1'b0);
    chk("abort_fill_wr", write_ram, 1'b1);
    average_done = 1'b1;
    tick();
    average_done = 1'b0;
    chk("idle_nowrite", write_ram, 1'b1);

`ifdef RAM_READBACK_EN
    // abort during READ
    start = 1'b1;
    tick();
    start = 1'b0;
    nxt_addr = TOP;
    writes(2048, 1'b1);
    read_req = 1'b1;
    for (int i = 0; i < 2048; i++) rd_q.push_back(TOP - AW'(i));
    tick();
    read_req = 1'b0;
    repeat (10) tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("abort_rd_off", read_ram, 1'b0);
    chk("abort_rd_busy", busy, 1'b0);
    chk("abort_rd_count", rd_q.size(), 2038);
    rd_q.delete();
    tick();
    tick();
    chk("abort_rdv_off", rd_valid, 1'b0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
